// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, synchronous-read memory between two
// masters. One command is latched at a time, driven onto the bus for a single
// ACCESS cycle, and read data is returned to its owner with a valid pulse.
module mem_arbiter #(
   parameter int unsigned PRIORITY = 0,
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m1_req,
   input  logic          m0_we,
   input  logic          m1_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_out,
   input  logic [DW-1:0] mem_data_in,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q;
   logic          owner_q;
   logic          last_owner_q;
   logic          cmd_we_q;
   logic [AW-1:0] cmd_addr_q;
   logic [DW-1:0] cmd_wdata_q;
   logic          m0_gnt_q;
   logic          m1_gnt_q;
   logic          m0_rvalid_q;
   logic          m1_rvalid_q;
   logic [DW-1:0] m0_rdata_q;
   logic [DW-1:0] m1_rdata_q;
   logic          mem_we_q;
   logic          busy_q;

   logic          arb_m1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Pick the winner among current requesters and mux its command.
   always_comb begin
      arb_m1 = 1'b0;
      if (m0_req && m1_req) begin
         // Round-robin hands a tie to the master not granted last.
         arb_m1 = (PRIORITY == 32'd0) ? ~last_owner_q : 1'b0;
      end else begin
         arb_m1 = m1_req;
      end
      sel_we    = arb_m1 ? m1_we    : m0_we;
      sel_addr  = arb_m1 ? m1_addr  : m0_addr;
      sel_wdata = arb_m1 ? m1_wdata : m0_wdata;
   end

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         m0_gnt_q     <= 1'b0;
         m1_gnt_q     <= 1'b0;
         m0_rvalid_q  <= 1'b0;
         m1_rvalid_q  <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         mem_we_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // Pulses last one cycle unless re-asserted below.
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  owner_q      <= arb_m1;
                  last_owner_q <= arb_m1;
                  cmd_we_q     <= sel_we;
                  cmd_addr_q   <= sel_addr;
                  cmd_wdata_q  <= sel_wdata;
                  mem_we_q     <= sel_we;
                  m0_gnt_q     <= ~arb_m1;
                  m1_gnt_q     <= arb_m1;
                  busy_q       <= 1'b1;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cmd_we_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               // Memory data for the ACCESS-cycle address is valid now.
               if (owner_q) begin
                  m1_rdata_q  <= mem_data_in;
                  m1_rvalid_q <= 1'b1;
               end else begin
                  m0_rdata_q  <= mem_data_in;
                  m0_rvalid_q <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Bus address/data hold the last latched command outside ACCESS.
   assign mem_address  = cmd_addr_q;
   assign mem_data_out = cmd_wdata_q;
   assign mem_we       = mem_we_q;
   assign m0_gnt       = m0_gnt_q;
   assign m1_gnt       = m1_gnt_q;
   assign m0_rvalid    = m0_rvalid_q;
   assign m1_rvalid    = m1_rvalid_q;
   assign m0_rdata     = m0_rdata_q;
   assign m1_rdata     = m1_rdata_q;
   assign busy         = busy_q;

endmodule
